// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch control in front of a synchronous
// instruction memory. Presents the PC as the memory read address, tracks the
// PC of the word the memory is currently returning, and marks that word valid.
// It also handles stall, branch and jump redirects, squashing the wrong-path
// word already in flight.
//
// Ports:
//   clk, rst_n       clock shared with the memory; async active-low reset
//   i_stall          hold the current fetch (decode not ready)
//   i_branch_taken   redirect to i_branch_target (highest priority)
//   i_branch_target  byte address of the branch destination
//   i_jump           redirect to the J-format target built from i_jump_index
//   i_jump_index     26-bit J-format index field
//   i_instruction    registered memory output (only qualified, never stored)
//   o_read_address   byte address to the memory (= PC)
//   o_fetch_pc       PC of the word currently on i_instruction
//   o_pc_plus4       o_fetch_pc + 4, wrapped to the memory size (combinational)
//   o_inst_valid     i_instruction is a live, non-squashed fetch
//   o_fetch_count    count of words accepted by decode (valid and not stalled)
module fetch_unit #(
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  input  logic [31:0] i_instruction,
  output logic [31:0] o_read_address,
  output logic [31:0] o_fetch_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_inst_valid,
  output logic [31:0] o_fetch_count
);

  // Keeps addresses word aligned and inside the memory.
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1) & ~32'd3;
  localparam logic [31:0] RST_PC    = 32'(RESET_PC);

  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        r_inst_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_seq_pc;
  logic [31:0] w_branch_pc;
  logic [31:0] w_jump_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_fetch_pc_nxt;
  logic        w_inst_valid_nxt;
  logic [31:0] w_fetch_count_nxt;
  logic        w_unused;

  // The instruction word passes straight to decode; it is only qualified here.
  assign w_unused = ^i_instruction;

  // Candidate next PCs, all sanitised to the memory range.
  assign w_pc_plus4  = (r_fetch_pc + 32'd4) & ADDR_MASK;
  assign w_seq_pc    = (r_pc + 32'd4) & ADDR_MASK;
  assign w_branch_pc = i_branch_target & ADDR_MASK;
  assign w_jump_pc   = {w_pc_plus4[31:28], i_jump_index, 2'b00} & ADDR_MASK;

  // Next-state selection: branch > jump > stall > sequential.
  always_comb begin
    w_pc_nxt          = r_pc;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_inst_valid_nxt  = r_inst_valid;
    w_fetch_count_nxt = r_fetch_count;

    if (r_inst_valid && !i_stall) begin
      w_fetch_count_nxt = r_fetch_count + 32'd1;
    end

    if (i_branch_taken) begin
      // Word sampled this edge is the sequential wrong-path fetch: squash it.
      w_pc_nxt         = w_branch_pc;
      w_fetch_pc_nxt   = r_pc;
      w_inst_valid_nxt = 1'b0;
    end else if (i_jump) begin
      w_pc_nxt         = w_jump_pc;
      w_fetch_pc_nxt   = r_pc;
      w_inst_valid_nxt = 1'b0;
    end else if (!i_stall) begin
      w_pc_nxt         = w_seq_pc;
      w_fetch_pc_nxt   = r_pc;
      w_inst_valid_nxt = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RST_PC;
      r_fetch_pc    <= RST_PC;
      r_inst_valid  <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_inst_valid  <= w_inst_valid_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign o_read_address = r_pc;
  assign o_fetch_pc     = r_fetch_pc;
  assign o_pc_plus4     = w_pc_plus4;
  assign o_inst_valid   = r_inst_valid;
  assign o_fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written reset sequence,
// then randomized stimulus against an arithmetic reference model.
module tb_fetch_unit;

  localparam int unsigned MEM = 256;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] instruction;
  logic [31:0] read_address;
  logic [31:0] fetch_pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic [31:0] fetch_count;

  int n_vec;
  int n_err;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_fpc;
  logic        m_valid;
  logic [31:0] m_cnt;

  fetch_unit #(.RESET_PC(0), .MEM_BYTES(MEM)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_jump          (jump),
    .i_jump_index    (jump_index),
    .i_instruction   (instruction),
    .o_read_address  (read_address),
    .o_fetch_pc      (fetch_pc),
    .o_pc_plus4      (pc_plus4),
    .o_inst_valid    (inst_valid),
    .o_fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [25:0] ji;
    logic [31:0] ra;
    logic [31:0] fpc;
    logic        v;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [25:0] ji);
    stall = st; branch_taken = br; branch_target = bt; jump = jp; jump_index = ji;
    instruction = $urandom;
  endtask

  // Model: PCs are byte addresses in a MEM-byte memory, targets word aligned.
  task automatic model_reset();
    m_pc = 0; m_fpc = 0; m_valid = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic st, input logic br, input logic [31:0] bt,
                            input logic jp, input logic [25:0] ji);
    logic [31:0] link;
    logic [31:0] tgt;
    link = (m_fpc + 4) % MEM;
    if (m_valid && !st) m_cnt = m_cnt + 1;
    if (br || jp) begin
      if (br) tgt = (bt % MEM) / 4 * 4;
      else    tgt = ((link / 32'h1000_0000) * 32'h1000_0000 + 32'(ji) * 4) % MEM;
      m_fpc   = m_pc;
      m_pc    = tgt;
      m_valid = 1'b0;
    end else if (!st) begin
      m_fpc   = m_pc;
      m_pc    = (m_pc + 4) % MEM;
      m_valid = 1'b1;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".read_address"}, read_address, m_pc);
    chk({tag, ".fetch_pc"},     fetch_pc,     m_fpc);
    chk({tag, ".pc_plus4"},     pc_plus4,     (m_fpc + 4) % MEM);
    chk({tag, ".inst_valid"},   32'(inst_valid), 32'(m_valid));
    chk({tag, ".fetch_count"},  fetch_count,  m_cnt);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk_model("reset");
  endtask

  task automatic model_step(input logic st, input logic br, input logic [31:0] bt,
                            input logic jp, input logic [25:0] ji, input string tag);
    drive(st, br, bt, jp, ji);
    @(posedge clk); #1;
    model_edge(st, br, bt, jp, ji);
    chk_model(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);

    //            st br bt            jp ji          ra         fpc        v  cnt
    vt[0]  = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h04, 32'h00, 1'b1, 32'd0};
    vt[1]  = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h08, 32'h04, 1'b1, 32'd1};
    vt[2]  = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h0C, 32'h08, 1'b1, 32'd2};
    vt[3]  = '{1'b1,1'b0,32'h0,      1'b0,26'h0,      32'h0C, 32'h08, 1'b1, 32'd2};
    vt[4]  = '{1'b1,1'b0,32'h0,      1'b0,26'h0,      32'h0C, 32'h08, 1'b1, 32'd2};
    vt[5]  = '{1'b1,1'b0,32'h0,      1'b0,26'h0,      32'h0C, 32'h08, 1'b1, 32'd2};
    vt[6]  = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h10, 32'h0C, 1'b1, 32'd3};
    vt[7]  = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h14, 32'h10, 1'b1, 32'd4};
    vt[8]  = '{1'b0,1'b1,32'h43,     1'b0,26'h0,      32'h40, 32'h14, 1'b0, 32'd5};
    vt[9]  = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h44, 32'h40, 1'b1, 32'd5};
    vt[10] = '{1'b0,1'b1,32'h10,     1'b1,26'h5,      32'h10, 32'h44, 1'b0, 32'd6};
    vt[11] = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h14, 32'h10, 1'b1, 32'd6};
    vt[12] = '{1'b1,1'b1,32'hFFFF_FF31,1'b1,26'h5,    32'h30, 32'h14, 1'b0, 32'd6};
    vt[13] = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h34, 32'h30, 1'b1, 32'd6};
    vt[14] = '{1'b0,1'b0,32'h0,      1'b1,26'h3FFFFFF,32'hFC, 32'h34, 1'b0, 32'd7};
    vt[15] = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h00, 32'hFC, 1'b1, 32'd7};
    vt[16] = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h04, 32'h00, 1'b1, 32'd8};
    vt[17] = '{1'b0,1'b0,32'h0,      1'b1,26'h2,      32'h08, 32'h04, 1'b0, 32'd9};
    vt[18] = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h0C, 32'h08, 1'b1, 32'd9};
    vt[19] = '{1'b1,1'b0,32'h0,      1'b1,26'h2,      32'h08, 32'h0C, 1'b0, 32'd9};
    vt[20] = '{1'b0,1'b0,32'h0,      1'b1,26'h2,      32'h08, 32'h08, 1'b0, 32'd9};
    vt[21] = '{1'b0,1'b0,32'h0,      1'b0,26'h0,      32'h0C, 32'h08, 1'b1, 32'd9};

    // Directed table
    do_reset();
    for (int i = 0; i < 22; i++) begin
      drive(vt[i].st, vt[i].br, vt[i].bt, vt[i].jp, vt[i].ji);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.read_address", i), read_address, vt[i].ra);
      chk($sformatf("vec%0d.fetch_pc", i),     fetch_pc,     vt[i].fpc);
      chk($sformatf("vec%0d.pc_plus4", i),     pc_plus4,     (vt[i].fpc + 32'd4) % MEM);
      chk($sformatf("vec%0d.inst_valid", i),   32'(inst_valid), 32'(vt[i].v));
      chk($sformatf("vec%0d.fetch_count", i),  fetch_count,  vt[i].cnt);
    end

    // Mid-stream async reset at PC=40, then restart
    do_reset();
    for (int i = 0; i < 10; i++) model_step(0, 0, 0, 0, 0, "run40");
    chk("pc_before_reset", read_address, 32'd40);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.read_address", read_address, 32'd0);
    chk("async_rst.fetch_pc",     fetch_pc,     32'd0);
    chk("async_rst.pc_plus4",     pc_plus4,     32'd4);
    chk("async_rst.inst_valid",   32'(inst_valid), 32'd0);
    chk("async_rst.fetch_count",  fetch_count,  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("restart.read_address", read_address, 32'd4);
    chk("restart.fetch_pc",     fetch_pc,     32'd0);
    chk("restart.inst_valid",   32'(inst_valid), 32'd1);
    chk("restart.fetch_count",  fetch_count,  32'd0);

    // Reset asserted during a redirect
    drive(0, 1, 32'h80, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_redirect.read_address", read_address, 32'd0);
    chk("rst_in_redirect.inst_valid",   32'(inst_valid), 32'd0);

    // Free-run past the wrap, then randomized traffic against the model
    do_reset();
    for (int i = 0; i < 70; i++) model_step(0, 0, 0, 0, 0, "wrap");
    for (int i = 0; i < 1500; i++) begin
      logic st;
      logic br;
      logic jp;
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 9) == 0);
      jp = ($urandom_range(0, 9) == 0);
      model_step(st, br, $urandom, jp, 26'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-control stage sitting directly upstream of the synchronous instruction memory. It drives the memory's byte read address, tracks which PC the memory's registered instruction output belongs to, and marks it valid for decode. It also applies stall, branch and jump redirects, and squashes the wrong-path fetch that is already in flight.

## Interface
- RESET_PC, 0, byte address fetched first after reset; multiple of 4, < MEM_BYTES
- MEM_BYTES, 256, instruction memory size in bytes; power of two, ≥ 8
- clk  in  1  rising-edge clock, shared with instruction memory
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold the current fetch (decode not ready)
- branch_taken  in  1  redirect to branch_target this cycle
- branch_target  in  32  byte address of branch destination
- jump  in  1  redirect to jump address this cycle
- jump_index  in  26  MIPS J-format index field
- instruction  in  32  registered output of instruction memory
- read_address  out  32  byte address to instruction memory (= PC)
- fetch_pc  out  32  PC of the word currently on `instruction`
- pc_plus4  out  32  fetch_pc + 4, wrapped modulo MEM_BYTES, for link/branch-offset use
- inst_valid  out  1  `instruction` is a live, non-squashed fetch
- fetch_count  out  32  number of cycles that had inst_valid=1 and stall=0, i.e. instructions accepted by decode

## Operation
- State registers:
  - PC, driven combinationally onto read_address.
  - fetch_pc.
  - inst_valid.
  - fetch_count.
- Next-PC selection, highest priority first:
  1. branch_taken: PC ← branch_target & (MEM_BYTES−1) & ~3.
  2. jump: PC ← {pc_plus4[31:28], jump_index, 2'b00} & (MEM_BYTES−1).
  3. stall: PC held.
  4. Otherwise: PC ← (PC + 4) mod MEM_BYTES.
- Target sanitising: the low 2 bits of any target are forced to 0. Bits at or above log2(MEM_BYTES) are dropped, so memory is never addressed out of range.
- Sequential wrap: MEM_BYTES−4 is followed by 0.
- Tracking register updates on every non-stalled edge:
  - fetch_pc ← PC, i.e. the address the memory is sampling this edge.
  - inst_valid ← 1, except:
    - Redirect (branch_taken or jump): inst_valid ← 0. The word fetched this cycle is the sequential wrong-path instruction (no delay slot) and is squashed.
    - Stall without redirect: fetch_pc and inst_valid are held. The memory re-reads the same address, so `instruction` is unchanged.
- Redirect during stall: the redirect wins. PC loads the target and inst_valid ← 0.
- fetch_count increments on every edge where inst_valid=1 and stall=0. It wraps at 2^32.
- The fetch unit does not store or modify `instruction`; it only qualifies it.

## Timing
- Reset (async assert, any time, including mid-redirect) forces:
  - PC = RESET_PC, so read_address = RESET_PC.
  - fetch_pc = RESET_PC.
  - pc_plus4 = RESET_PC + 4.
  - inst_valid = 0.
  - fetch_count = 0.
- Reset release is synchronous to the next rising clk edge. Edge 1 after release: fetch_pc = RESET_PC, inst_valid = 1.
- Fetch latency is 1 cycle. An address presented before edge N is reflected in instruction, fetch_pc and inst_valid after edge N.
- Redirect latency:
  - The redirect input is sampled at edge N.
  - After edge N, read_address = target and inst_valid = 0 (1 bubble).
  - After edge N+1, fetch_pc = target and inst_valid = 1.
- A redirect held high for k cycles reloads the same target each cycle, giving k bubbles.
- Stall is level-sensitive with no latency. While asserted without a redirect, all outputs are frozen.
- pc_plus4 is combinational from fetch_pc.

## Test plan
- Reset then free-run, MEM_BYTES=256 → read_address 0,4,8,…; fetch_pc lags one cycle; inst_valid=1 from edge 1; fetch_pc reaches 252 then 0.
- stall high for 3 cycles while read_address=12 → read_address, fetch_pc=8 and inst_valid held; fetch_count frozen; sequence resumes at 16.
- branch_taken with branch_target=0x0000_0043 at PC=20 → read_address=0x40 next; one cycle inst_valid=0 with fetch_pc=20; then fetch_pc=0x40, valid.
- branch_taken and jump together (jump_index=5) → branch target wins; same cycle with stall=1 → redirect still taken.
- jump_index=0x3FFFFFF, MEM_BYTES=256 → target 0xFC; jump_index=2 → target 8.
- rst_n pulsed low mid-stream at PC=40 → immediately read_address=0, inst_valid=0, fetch_count=0; restart as in first scenario.
